ps2_rx_fifo: RTL and testbench

- Fully synchronous PS/2 device-to-host receiver: one system clock, no logic clocked by the keyboard clock.
- Filters and synchronises kclk/kdata, decodes 11-bit frames and checks start, parity and stop bits.
- Recovers from stalled frames by timeout; buffers good bytes in a FIFO with a valid/ready output.
- Keeps a 16-bit two-byte history of consumed bytes for the downstream keycode decoder and display path.

---
 rtl/ps2_rx_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: line filtering, frame decode with timeout,
// byte FIFO with valid/ready output and a two-byte history of consumed bytes.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 19,
  parameter int FILTER_W    = 5,
  parameter int TIMEOUT_CYC = 200000,
  parameter int TIMEOUT_W   = 18,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               kclk,
  input  logic               kdata,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [15:0]        keycode,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [FILTER_W-1:0]  FILT_LAST = FILTER_W'(FILTER_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [FIFO_AW:0]     FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  // Returns {next filtered level, next run counter}.
  function automatic logic [FILTER_W:0] filter_step(
    input logic                s,
    input logic                f,
    input logic [FILTER_W-1:0] cnt
  );
    logic [FILTER_W:0] r;
    if (s == f) begin
      r = {f, {FILTER_W{1'b0}}};
    end else if (cnt == FILT_LAST) begin
      r = {s, {FILTER_W{1'b0}}};
    end else begin
      r = {f, cnt + 1'b1};
    end
    return r;
  endfunction

  // ---- stage: synchronisers and glitch filters ----
  logic [1:0]          kclk_sync_q, kdata_sync_q;
  logic                kclk_f_q, kclk_f_d, kdata_f_q, kdata_f_d;
  logic [FILTER_W-1:0] kclk_cnt_q, kclk_cnt_d, kdata_cnt_q, kdata_cnt_d;
  logic                kclk_fd_q;
  logic                fall;

  always_comb begin
    {kclk_f_d, kclk_cnt_d}   = filter_step(kclk_sync_q[1], kclk_f_q, kclk_cnt_q);
    {kdata_f_d, kdata_cnt_d} = filter_step(kdata_sync_q[1], kdata_f_q, kdata_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync_q  <= 2'b11;
      kdata_sync_q <= 2'b11;
      kclk_f_q     <= 1'b1;
      kdata_f_q    <= 1'b1;
      kclk_cnt_q   <= '0;
      kdata_cnt_q  <= '0;
      kclk_fd_q    <= 1'b1;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[0], kclk};
      kdata_sync_q <= {kdata_sync_q[0], kdata};
      kclk_f_q     <= kclk_f_d;
      kdata_f_q    <= kdata_f_d;
      kclk_cnt_q   <= kclk_cnt_d;
      kdata_cnt_q  <= kdata_cnt_d;
      kclk_fd_q    <= kclk_f_q;
    end
  end

  assign fall = kclk_fd_q & ~kclk_f_q;

  // ---- stage: frame decoder ----
  logic [1:0]           state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic                 timeout_hit;
  logic                 push_req;
  logic                 perr_d, ferr_d;

  // to_q holds the number of cycles since the last fall while inside a frame.
  assign timeout_hit = (state_q != S_IDLE) && (to_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_req  = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (timeout_hit || (state_q == S_IDLE && !fall)) begin
      to_d = '0;
    end else if (fall) begin
      to_d = TIMEOUT_W'(1);
    end else begin
      to_d = to_q + 1'b1;
    end

    if (timeout_hit) begin
      state_d = S_IDLE;
      shift_d = '0;
      ferr_d  = 1'b1;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!kdata_f_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {kdata_f_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = kdata_f_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!kdata_f_q) begin
            ferr_d = 1'b1;
          end else if (^{shift_q, par_q} != 1'b1) begin
            perr_d = 1'b1;
          end else begin
            push_req = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_q      <= to_d;
    end
  end

  // ---- stage: FIFO, history and status pulses ----
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [15:0]        keycode_q;
  logic               perr_q, ferr_q, ovf_q;
  logic               pop, push, full, ovf_d;

  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid & rx_ready;
  assign full     = (count_q == FIFO_FULL);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign ovf_d    = push_req & full & ~pop;

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      keycode_q <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        keycode_q <= {keycode_q[7:0], mem_q[rd_ptr_q]};
      end
      count_q <= count_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign keycode    = keycode_q;
  assign fifo_count = count_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: table of whole frames plus hand-written sequences
// for timeout, overflow, glitches and mid-frame reset; bytes checked via a queue.
module tb_ps2_rx_fifo;

  localparam int FL   = 4;
  localparam int TC   = 1000;
  localparam int FD   = 4;
  localparam int FAW  = 2;
  localparam int HALF = 50;

  logic           clk, rst_n, kclk, kdata, rx_ready;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [15:0]    keycode;
  logic [FAW:0]   fifo_count;
  logic           parity_err, frame_err, overflow;

  ps2_rx_fifo #(
    .FILTER_LEN(FL), .FILTER_W(5), .TIMEOUT_CYC(TC), .TIMEOUT_W(10),
    .FIFO_DEPTH(FD), .FIFO_AW(FAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .keycode(keycode), .fifo_count(fifo_count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         stop;
    bit         push;
    int         perr;
    int         ferr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] kc_model = '0;
  bit          kc_pending = 0;
  int          perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, valid_cyc = 0;
  int          ferr_cyc = -1, first_valid_cyc = -1;
  bit          valid_prev = 0;
  int          last_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives nfalls bits of a frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                            input int nfalls, input bit glitch);
    logic [10:0] bits;
    logic        p;
    bit          g;
    p    = (~^d) ^ bad_par;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      g = glitch && (i == 4);
      repeat (10) @(posedge clk); #1 if (g) kclk = 1'b0;
      repeat (2) @(posedge clk);  #1 kclk = 1'b1;
      repeat (13) @(posedge clk); #1 kdata = bits[i];
      repeat (HALF / 2) @(posedge clk); #1 kclk = 1'b0; last_fall_cyc = cyc;
      repeat (20) @(posedge clk); #1 if (g) kdata = ~kdata;
      repeat (2) @(posedge clk);  #1 kdata = bits[i];
      repeat (HALF - 22) @(posedge clk); #1 kclk = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_keycode"}, keycode, 0);
    check({tag, "_pulses"}, {parity_err, frame_err, overflow}, 0);
  endtask

  vec_t vecs [10];
  int   p0, f0, o0, v0, c_stop;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[4] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[7] = '{8'h5A, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[8] = '{8'h55, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[9] = '{8'hA5, 1'b0, 1'b1, 1'b1, 0, 0};

    rst_n = 1'b0; kclk = 1'b1; kdata = 1'b1; rx_ready = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (kc_pending) begin
            check("keycode", keycode, kc_model);
            kc_pending = 0;
          end
          if (parity_err) perr_cnt++;
          if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
          if (overflow) ovf_cnt++;
          if (rx_valid) valid_cyc++;
          if (rx_valid && !valid_prev) first_valid_cyc = cyc;
          valid_prev = rx_valid;
          if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_pop", rx_data, 32'hFFFF_FFFF);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              check("rx_data", rx_data, e);
              kc_model = {kc_model[7:0], e};
              kc_pending = 1;
            end
          end
        end
      end
      begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not complete");
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Table of complete frames, consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p0 = perr_cnt; f0 = ferr_cnt; v0 = valid_cyc;
      if (vecs[i].push) exp_q.push_back(vecs[i].d);
      send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop, 11, 1'b0);
      c_stop = last_fall_cyc;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_perr", i), perr_cnt - p0, vecs[i].perr);
      check($sformatf("v%0d_ferr", i), ferr_cnt - f0, vecs[i].ferr);
      check($sformatf("v%0d_valid_cycles", i), valid_cyc - v0, {31'd0, vecs[i].push});
      check($sformatf("v%0d_count", i), fifo_count, 0);
      // kclk edge -> 2 sync flops -> FL filter cycles -> fall cycle -> write.
      if (i == 0) check("latency", first_valid_cyc, c_stop + FL + 3);
      if (i == 2) check("keycode_F01C", keycode, 16'hF01C);
    end

    // Stalled frame: start plus 3 data bits, then kclk held high.
    f0 = ferr_cnt; v0 = valid_cyc;
    send_frame(8'h00, 1'b0, 1'b1, 4, 1'b0);
    c_stop = last_fall_cyc;
    repeat (TC + 60) @(posedge clk);
    @(negedge clk);
    check("timeout_ferr", ferr_cnt - f0, 1);
    // Detected TC-1 cycles after the fall cycle, visible one cycle later.
    check("timeout_cycle", ferr_cyc, c_stop + FL + 2 + TC);
    check("timeout_novalid", valid_cyc - v0, 0);
    v0 = valid_cyc;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("after_timeout_valid", valid_cyc - v0, 1);

    // Overflow: consumer stalled, five bytes into a four-entry FIFO.
    rx_ready = 1'b0;
    o0 = ovf_cnt;
    for (int k = 1; k <= 5; k++) begin
      if (k <= FD) exp_q.push_back(k[7:0]);
      send_frame(k[7:0], 1'b0, 1'b1, 11, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      if (k == 4) check("ovf_before_5th", ovf_cnt - o0, 0);
    end
    check("ovf_count", fifo_count, FD);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_head", rx_data, 8'h01);
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ovf_drained", fifo_count, 0);
    check("ovf_keycode", keycode, 16'h0304);

    // Glitches on both lines mid-frame.
    p0 = perr_cnt; f0 = ferr_cnt; v0 = valid_cyc;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);
    check("glitch_valid", valid_cyc - v0, 1);

    // Reset in the middle of a frame.
    send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    kc_model = '0;
    repeat (4) @(posedge clk); #1 rst_n = 1'b1;
    v0 = valid_cyc;
    exp_q.push_back(8'h3A);
    send_frame(8'h3A, 1'b0, 1'b1, 11, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_reset_valid", valid_cyc - v0, 1);
    check("post_reset_keycode", keycode, 16'h003A);

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
